// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : RV32I subset ID stage: register file, decode, in-ID branch
//             resolution, load-use/branch hazard stall, ID/EX pipeline register
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instrucao,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    output logic        load_pc,
    output logic        load_if_id_register,
    output logic        mux_sel,
    output logic [31:0] pc_branch_value,
    output logic        idex_valid,
    output logic [31:0] idex_pc,
    output logic [31:0] idex_rs1_data,
    output logic [31:0] idex_rs2_data,
    output logic [31:0] idex_imm,
    output logic [4:0]  idex_rs1,
    output logic [4:0]  idex_rs2,
    output logic [4:0]  idex_rd,
    output logic [3:0]  idex_alu_op,
    output logic        idex_alu_src,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_reg_write,
    output logic        idex_mem_to_reg,
    output logic        idex_link
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        link;
    } idex_t;

    logic [31:0][31:0] regs_q, regs_d;
    logic              squash_q, squash_d;
    idex_t             idex_q, idex_d;

    logic [6:0]  opcode;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    idex_t       dec;
    logic        uses_rs1, uses_rs2, is_branch, is_jal;
    logic [31:0] rs1_val, rs2_val, target;
    logic        load_use, br_stall, stall, taken, redirect;

    assign opcode = instrucao[6:0];
    assign f_rd   = instrucao[11:7];
    assign f3     = instrucao[14:12];
    assign f_rs1  = instrucao[19:15];
    assign f_rs2  = instrucao[24:20];
    assign f7b5   = instrucao[30];

    assign imm_i = {{20{instrucao[31]}}, instrucao[31:20]};
    assign imm_s = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
    assign imm_b = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                    instrucao[30:25], instrucao[11:8], 1'b0};
    assign imm_j = {{11{instrucao[31]}}, instrucao[31], instrucao[19:12],
                    instrucao[20], instrucao[30:21], 1'b0};

    // Unused source indices stay 0 so they read x0 and never match a hazard.
    always_comb begin
        dec       = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        if (!squash_q) begin
            case (opcode)
                OP_R: begin
                    dec.valid     = 1'b1;
                    dec.rs1       = f_rs1;
                    dec.rs2       = f_rs2;
                    dec.rd        = f_rd;
                    dec.alu_op    = {f7b5, f3};
                    dec.reg_write = (f_rd != 5'd0);
                    uses_rs1      = 1'b1;
                    uses_rs2      = 1'b1;
                end
                OP_I: begin
                    dec.valid     = 1'b1;
                    dec.rs1       = f_rs1;
                    dec.rd        = f_rd;
                    dec.imm       = imm_i;
                    dec.alu_op    = {f7b5 & (f3 == 3'b101), f3};
                    dec.alu_src   = 1'b1;
                    dec.reg_write = (f_rd != 5'd0);
                    uses_rs1      = 1'b1;
                end
                OP_LW: begin
                    if (f3 == 3'b010) begin
                        dec.valid      = 1'b1;
                        dec.rs1        = f_rs1;
                        dec.rd         = f_rd;
                        dec.imm        = imm_i;
                        dec.alu_src    = 1'b1;
                        dec.mem_read   = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.reg_write  = (f_rd != 5'd0);
                        uses_rs1       = 1'b1;
                    end
                end
                OP_SW: begin
                    if (f3 == 3'b010) begin
                        dec.valid     = 1'b1;
                        dec.rs1       = f_rs1;
                        dec.rs2       = f_rs2;
                        dec.imm       = imm_s;
                        dec.alu_src   = 1'b1;
                        dec.mem_write = 1'b1;
                        uses_rs1      = 1'b1;
                        uses_rs2      = 1'b1;
                    end
                end
                OP_BR: begin
                    if (f3 == 3'b000 || f3 == 3'b001) begin
                        dec.valid = 1'b1;
                        dec.rs1   = f_rs1;
                        dec.rs2   = f_rs2;
                        dec.imm   = imm_b;
                        uses_rs1  = 1'b1;
                        uses_rs2  = 1'b1;
                        is_branch = 1'b1;
                    end
                end
                OP_JAL: begin
                    dec.valid     = 1'b1;
                    dec.rd        = f_rd;
                    dec.imm       = imm_j;
                    dec.link      = 1'b1;
                    dec.reg_write = (f_rd != 5'd0);
                    is_jal        = 1'b1;
                end
                default: ;
            endcase
            if (dec.valid) begin
                dec.pc = pc_in;
            end
        end
    end

    // Reads see a same-cycle writeback; x0 is hard-wired to zero.
    assign rs1_val = (dec.rs1 == 5'd0) ? 32'd0 :
                     (wb_reg_write && wb_rd == dec.rs1) ? wb_data : regs_q[dec.rs1];
    assign rs2_val = (dec.rs2 == 5'd0) ? 32'd0 :
                     (wb_reg_write && wb_rd == dec.rs2) ? wb_data : regs_q[dec.rs2];

    always_comb begin
        load_use = idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                   ((uses_rs1 && dec.rs1 == idex_q.rd) ||
                    (uses_rs2 && dec.rs2 == idex_q.rd));
        br_stall = is_branch &&
                   ((idex_q.reg_write && idex_q.rd != 5'd0 &&
                     (dec.rs1 == idex_q.rd || dec.rs2 == idex_q.rd)) ||
                    (exmem_reg_write && exmem_rd != 5'd0 &&
                     (dec.rs1 == exmem_rd || dec.rs2 == exmem_rd)));
        stall    = load_use || br_stall;
        taken    = is_jal || (is_branch && ((rs1_val == rs2_val) != f3[0]));
        target   = pc_in + dec.imm;
        redirect = taken && !stall;

        load_pc             = !stall;
        load_if_id_register = !stall;
        mux_sel             = redirect;
        pc_branch_value     = redirect ? target : 32'd0;
        squash_d            = redirect;

        idex_d          = dec;
        idex_d.rs1_data = rs1_val;
        idex_d.rs2_data = rs2_val;
        if (stall) begin
            idex_d = '0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_reg_write && wb_rd != 5'd0) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q   <= '0;
            squash_q <= 1'b0;
            idex_q   <= '0;
        end else begin
            regs_q   <= regs_d;
            squash_q <= squash_d;
            idex_q   <= idex_d;
        end
    end

    assign idex_valid      = idex_q.valid;
    assign idex_pc         = idex_q.pc;
    assign idex_rs1_data   = idex_q.rs1_data;
    assign idex_rs2_data   = idex_q.rs2_data;
    assign idex_imm        = idex_q.imm;
    assign idex_rs1        = idex_q.rs1;
    assign idex_rs2        = idex_q.rs2;
    assign idex_rd         = idex_q.rd;
    assign idex_alu_op     = idex_q.alu_op;
    assign idex_alu_src    = idex_q.alu_src;
    assign idex_mem_read   = idex_q.mem_read;
    assign idex_mem_write  = idex_q.mem_write;
    assign idex_reg_write  = idex_q.reg_write;
    assign idex_mem_to_reg = idex_q.mem_to_reg;
    assign idex_link       = idex_q.link;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : directed self-checking bench for decode_stage
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic        clock, reset;
    logic [31:0] pc_in, instrucao, wb_data;
    logic        wb_reg_write, exmem_reg_write;
    logic [4:0]  wb_rd, exmem_rd;
    logic        load_pc, load_if_id_register, mux_sel;
    logic [31:0] pc_branch_value, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic        idex_valid, idex_alu_src, idex_mem_read, idex_mem_write;
    logic        idex_reg_write, idex_mem_to_reg, idex_link;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [3:0]  idex_alu_op;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .instrucao(instrucao),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .load_pc(load_pc), .load_if_id_register(load_if_id_register),
        .mux_sel(mux_sel), .pc_branch_value(pc_branch_value),
        .idex_valid(idex_valid), .idex_pc(idex_pc),
        .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
        .idex_imm(idex_imm), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .idex_rd(idex_rd), .idex_alu_op(idex_alu_op),
        .idex_alu_src(idex_alu_src), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_reg_write(idex_reg_write),
        .idex_mem_to_reg(idex_mem_to_reg), .idex_link(idex_link)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        instrucao = 32'h0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; pc_in = 32'h0; instrucao = 32'h0; wb_reg_write = 1'b0;
        wb_rd = 5'd0; wb_data = 32'h0; exmem_reg_write = 1'b0; exmem_rd = 5'd0;
        step(); step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", idex_valid); end
        checks++; if (idex_rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rs1_data got %h exp 0", idex_rs1_data); end
        reset = 1'b1;
        step();
        checks++; if ({load_pc, load_if_id_register, mux_sel} !== 3'b110) begin errors++; $display("FAIL rst_ctrl got %b exp 110", {load_pc, load_if_id_register, mux_sel}); end
        checks++; if (pc_branch_value !== 32'h0) begin errors++; $display("FAIL rst_pcbv got %h exp 0", pc_branch_value); end
    endtask

    task automatic test_bypass();
        idle();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        pc_in = 32'h10; instrucao = 32'h00028333;              // add x6,x5,x0
        step();
        wb_reg_write = 1'b0;
        checks++; if (idex_rs1_data !== 32'h1234) begin errors++; $display("FAIL bypass_rs1 got %h exp 1234", idex_rs1_data); end
        checks++; if ({idex_valid, idex_reg_write, idex_rd} !== 7'b11_00110) begin errors++; $display("FAIL bypass_ctrl got %b exp 1100110", {idex_valid, idex_reg_write, idex_rd}); end
        checks++; if (idex_pc !== 32'h10) begin errors++; $display("FAIL bypass_pc got %h exp 10", idex_pc); end
        instrucao = 32'h005283B3;                               // add x7,x5,x5
        step();
        checks++; if ({idex_rs1_data, idex_rs2_data} !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL rf_read got %h exp 0000123400001234", {idex_rs1_data, idex_rs2_data}); end
    endtask

    task automatic test_alu_decode();
        instrucao = 32'h40028433;                               // sub x8,x5,x0
        step();
        checks++; if (idex_alu_op !== 4'h8) begin errors++; $display("FAIL sub_aluop got %h exp 8", idex_alu_op); end
        instrucao = 32'h4022D493;                               // srai x9,x5,2
        step();
        checks++; if ({idex_alu_op, idex_alu_src} !== 5'b1101_1) begin errors++; $display("FAIL srai_ctrl got %b exp 11011", {idex_alu_op, idex_alu_src}); end
        checks++; if (idex_imm !== 32'h402) begin errors++; $display("FAIL srai_imm got %h exp 402", idex_imm); end
        instrucao = 32'hFFF00513;                               // addi x10,x0,-1
        step();
        checks++; if (idex_alu_op !== 4'h0) begin errors++; $display("FAIL addi_aluop got %h exp 0", idex_alu_op); end
        checks++; if (idex_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", idex_imm); end
    endtask

    task automatic test_load_use();
        idle();
        pc_in = 32'h40; instrucao = 32'h00002083;               // lw x1,0(x0)
        step();
        checks++; if ({idex_mem_read, idex_mem_to_reg, idex_rd} !== 7'b11_00001) begin errors++; $display("FAIL lw_ctrl got %b exp 1100001", {idex_mem_read, idex_mem_to_reg, idex_rd}); end
        pc_in = 32'h44; instrucao = 32'h00308133;               // add x2,x1,x3
        #1;
        checks++; if ({load_pc, load_if_id_register} !== 2'b00) begin errors++; $display("FAIL lu_stall got %b exp 00", {load_pc, load_if_id_register}); end
        step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", idex_valid); end
        checks++; if (load_pc !== 1'b1) begin errors++; $display("FAIL lu_resume got %h exp 1", load_pc); end
        step();
        checks++; if ({idex_valid, idex_rd} !== 6'b1_00010) begin errors++; $display("FAIL lu_issue got %b exp 100010", {idex_valid, idex_rd}); end
    endtask

    task automatic test_branch();
        idle();
        pc_in = 32'h20; instrucao = 32'h00000863;               // beq x0,x0,+16
        #1;
        checks++; if ({mux_sel, load_pc} !== 2'b11) begin errors++; $display("FAIL beq_sel got %b exp 11", {mux_sel, load_pc}); end
        checks++; if (pc_branch_value !== 32'h30) begin errors++; $display("FAIL beq_target got %h exp 30", pc_branch_value); end
        step();
        checks++; if ({idex_valid, idex_reg_write} !== 2'b10) begin errors++; $display("FAIL beq_idex got %b exp 10", {idex_valid, idex_reg_write}); end
        pc_in = 32'h24; instrucao = 32'h005283B3;
        #1;
        checks++; if (mux_sel !== 1'b0) begin errors++; $display("FAIL squash_sel got %h exp 0", mux_sel); end
        step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL squash_bubble got %h exp 0", idex_valid); end
        step();
        checks++; if (idex_valid !== 1'b1) begin errors++; $display("FAIL squash_clear got %h exp 1", idex_valid); end
        instrucao = 32'h00001863;                               // bne x0,x0,+16
        #1;
        checks++; if ({mux_sel, pc_branch_value} !== 33'h0) begin errors++; $display("FAIL bne_nt got %h exp 0", {mux_sel, pc_branch_value}); end
    endtask

    task automatic test_branch_stall();
        idle();
        pc_in = 32'h100; exmem_reg_write = 1'b1; exmem_rd = 5'd5;
        instrucao = 32'h00528863;                               // beq x5,x5,+16
        #1;
        checks++; if ({load_pc, mux_sel, pc_branch_value} !== 34'h0) begin errors++; $display("FAIL exm_stall got %h exp 0", {load_pc, mux_sel, pc_branch_value}); end
        step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL exm_bubble got %h exp 0", idex_valid); end
        exmem_reg_write = 1'b0;
        #1;
        checks++; if ({mux_sel, pc_branch_value} !== {1'b1, 32'h110}) begin errors++; $display("FAIL exm_resume got %h exp 100000110", {mux_sel, pc_branch_value}); end
        step();
        idle();
        instrucao = 32'hFFF00513;                               // addi x10,x0,-1
        step();
        instrucao = 32'h00051863;                               // bne x10,x0,+16
        #1;
        checks++; if ({load_pc, load_if_id_register} !== 2'b00) begin errors++; $display("FAIL idex_br_stall got %b exp 00", {load_pc, load_if_id_register}); end
        step();
    endtask

    task automatic test_jal();
        idle();
        pc_in = 32'h0; instrucao = 32'hFF9FF0EF;                // jal x1,-8
        #1;
        checks++; if ({mux_sel, pc_branch_value} !== {1'b1, 32'hFFFFFFF8}) begin errors++; $display("FAIL jal_target got %h exp 1fffffff8", {mux_sel, pc_branch_value}); end
        step();
        checks++; if ({idex_link, idex_reg_write, idex_rd} !== 7'b11_00001) begin errors++; $display("FAIL jal_idex got %b exp 1100001", {idex_link, idex_reg_write, idex_rd}); end
        checks++; if (idex_imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL jal_imm got %h exp fffffff8", idex_imm); end
        instrucao = 32'h00028333;
        step();
        checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL jal_squash got %h exp 0", idex_valid); end
    endtask

    task automatic test_store();
        idle();
        instrucao = 32'h00502223;                               // sw x5,4(x0)
        step();
        checks++; if ({idex_mem_write, idex_reg_write, idex_alu_src} !== 3'b101) begin errors++; $display("FAIL sw_ctrl got %b exp 101", {idex_mem_write, idex_reg_write, idex_alu_src}); end
        checks++; if ({idex_imm, idex_rs2_data} !== {32'h4, 32'h1234}) begin errors++; $display("FAIL sw_data got %h exp 0000000400001234", {idex_imm, idex_rs2_data}); end
        instrucao = 32'hFE002E23;                               // sw x0,-4(x0)
        step();
        checks++; if (idex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_negimm got %h exp fffffffc", idex_imm); end
    endtask

    task automatic test_illegal_and_x0();
        instrucao = 32'h00028333; step();
        instrucao = 32'h0000007F;
        step();
        checks++; if ({idex_valid, load_pc, mux_sel} !== 3'b010) begin errors++; $display("FAIL op7f got %b exp 010", {idex_valid, load_pc, mux_sel}); end
        instrucao = 32'h00028333; step();
        instrucao = 32'h00000083;                               // lb: unsupported funct3
        step();
        checks++; if ({idex_valid, idex_mem_read} !== 2'b00) begin errors++; $display("FAIL lb_bubble got %b exp 00", {idex_valid, idex_mem_read}); end
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        instrucao = 32'h00000333;                               // add x6,x0,x0
        step();
        wb_reg_write = 1'b0;
        checks++; if (idex_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", idex_rs1_data); end
        step();
        checks++; if (idex_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp 0", idex_rs1_data); end
    endtask

    task automatic test_reset_mid();
        idle();
        pc_in = 32'h40; instrucao = 32'h00002083; step();
        instrucao = 32'h00308133;
        #1;
        checks++; if (load_pc !== 1'b0) begin errors++; $display("FAIL mid_prestall got %h exp 0", load_pc); end
        reset = 1'b0;
        #1;
        checks++; if ({idex_valid, idex_mem_read, idex_rd, idex_pc} !== 39'h0) begin errors++; $display("FAIL mid_idex got %h exp 0", {idex_valid, idex_mem_read, idex_rd, idex_pc}); end
        checks++; if (load_pc !== 1'b1) begin errors++; $display("FAIL mid_loadpc got %h exp 1", load_pc); end
        reset = 1'b1;
        step();
        pc_in = 32'h0; instrucao = 32'hFF9FF0EF;
        step();
        reset = 1'b0;
        #1;
        checks++; if (idex_link !== 1'b0) begin errors++; $display("FAIL mid_link got %h exp 0", idex_link); end
        reset = 1'b1;
        instrucao = 32'h005283B3;
        step();
        checks++; if ({idex_valid, idex_rs1_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mid_squash_regs got %h exp 100000000", {idex_valid, idex_rs1_data}); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_alu_decode();
        test_load_use();
        test_branch();
        test_branch_stall();
        test_jal();
        test_store();
        test_illegal_and_x0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
